// File: rtl/alu_pkg.sv
// Shared ALU types and constants for the serial add/sub sequencer.
// Holds the FSM state enum, the slice width and the index-width helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } addsub_state_t;

  localparam int SLICE_W = 4;

  // Slice-index width; a single-slice build still needs one bit.
  function automatic int idx_w(input int width);
    int n;
    n = width / SLICE_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// All carries are computed in parallel from generate/propagate terms.
module cla_slice4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0]
                | (w_p[0] & i_ci);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_ci);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);

  assign o_s  = w_p ^ w_c[3:0];
  assign o_co = w_c[4];

endmodule

// File: rtl/serial_addsub_seq.sv
// Nibble-serial WIDTH-bit add/subtract over one shared CLA slice.
// Define SERIAL_ADDSUB_OVF_EN to add the signed overflow output.
module serial_addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             done
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  addsub_state_t r_state;
  addsub_state_t w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cy;
  logic [IW-1:0]      r_idx;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;
  logic               r_done;

  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_sum;
  logic               w_co;
  logic [WIDTH-1:0]   w_res_nxt;
  logic               w_last;
  logic               w_accept;

  assign w_last   = (r_idx == LAST);
  assign w_accept = start && (r_state != RUN);

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_nib = r_a[k*SLICE_W +: SLICE_W];
        w_b_nib = r_b[k*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_slice4 u_slice (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_cy),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  always_comb begin
    w_res_nxt = r_result;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_res_nxt[k*SLICE_W +: SLICE_W] = w_sum;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: w_next = start ? RUN : IDLE;
      RUN:        w_next = w_last ? DONE : RUN;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cy     <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= sub ? ~b : b;
        r_cy     <= sub | carry_in;
        r_idx    <= '0;
        r_result <= '0;
      end else if (r_state == RUN) begin
        r_result <= w_res_nxt;
        r_cy     <= w_co;
        if (w_last) begin
          r_idx  <= '0;
          r_cout <= w_co;
          r_done <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Same-sign operands whose sum flips sign.
  assign w_ovf = (w_a_nib[SLICE_W-1] == w_b_nib[SLICE_W-1])
              && (w_sum[SLICE_W-1] != w_a_nib[SLICE_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && r_state == RUN && w_last) begin
      r_ovf <= w_ovf;
    end
  end

  assign overflow = r_ovf;
`endif

  assign ready     = (r_state != RUN);
  assign busy      = (r_state == RUN);
  assign result    = r_result;
  assign carry_out = r_cout;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq with WIDTH=16.
// Overflow checks compile in when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        ready;
  logic        busy;
  logic [15:0] result;
  logic        carry_out;
  logic        done;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic        overflow;
`endif

  int n_chk;
  int n_fail;

  serial_addsub_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .ready     (ready),
    .busy      (busy),
    .result    (result),
    .carry_out (carry_out),
    .done      (done)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Drive one request for the accepting edge; leaves us 1ns after it.
  task automatic issue(input logic [15:0] a_,
                       input logic [15:0] b_,
                       input logic s_,
                       input logic c_);
    @(negedge clk);
    start    = 1'b1;
    a        = a_;
    b        = b_;
    sub      = s_;
    carry_in = c_;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges from the accepting edge to done; 10 means timed out.
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      n = k;
      if (done) break;
    end
  endtask

  int n;
  int nd;
  int d1;
  int d2;
  logic [15:0] res_snap;

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_cout", 32'(carry_out), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("rst_ovf", 32'(overflow), 32'h0);
`endif
    rst = 1'b0;

    // FFFF + 0001 wraps to zero with carry out
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("add_busy", 32'(busy), 32'h1);
    chk("add_ready", 32'(ready), 32'h0);
    wait_done(n);
    chk("add_lat", 32'(n), 32'd4);
    chk("add_res", 32'(result), 32'h0000);
    chk("add_cout", 32'(carry_out), 32'h1);
    chk("add_done_rdy", 32'(ready), 32'h1);
    @(posedge clk);
    #1;
    chk("add_done_pulse", 32'(done), 32'h0);
    chk("add_hold", 32'(result), 32'h0000);
    chk("add_hold_cout", 32'(carry_out), 32'h1);

    // 1234 - 1235 borrows
    issue(16'h1234, 16'h1235, 1'b1, 1'b1);
    wait_done(n);
    chk("sub_lat", 32'(n), 32'd4);
    chk("sub_res", 32'(result), 32'hFFFF);
    chk("sub_cout", 32'(carry_out), 32'h0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("sub_ovf", 32'(overflow), 32'h0);
`endif

    // carry_in used in add mode: 0F0F + 00F1 + 1
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    wait_done(n);
    chk("cin_res", 32'(result), 32'h1001);
    chk("cin_cout", 32'(carry_out), 32'h0);

`ifdef SERIAL_ADDSUB_OVF_EN
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    chk("ovf_add_res", 32'(result), 32'h8000);
    chk("ovf_add_ovf", 32'(overflow), 32'h1);
    chk("ovf_add_cout", 32'(carry_out), 32'h0);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0);
    wait_done(n);
    chk("ovf_sub_res", 32'(result), 32'h7FFF);
    chk("ovf_sub_ovf", 32'(overflow), 32'h1);
    chk("ovf_sub_cout", 32'(carry_out), 32'h1);
`endif

    // start pulsed mid-RUN must be ignored
    issue(16'h00F0, 16'h0010, 1'b0, 1'b0);
    start    = 1'b1;
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    nd       = 0;
    res_snap = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) res_snap = result;
      end
    end
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_res", 32'(res_snap), 32'h0100);

    // back-to-back with start held through DONE
    @(negedge clk);
    start    = 1'b1;
    a        = 16'hAAAA;
    b        = 16'h5555;
    sub      = 1'b0;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    a   = 16'h0001;
    b   = 16'h0001;
    sub = 1'b1;
    d1  = 0;
    d2  = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        start = 1'b0;
        chk("b2b_drop", 32'(done), 32'h0);
      end
      if (done && d1 == 0) begin
        d1 = k;
        chk("b2b_res1", 32'(result), 32'hFFFF);
        chk("b2b_cout1", 32'(carry_out), 32'h0);
      end else if (done && d2 == 0) begin
        d2 = k;
        chk("b2b_res2", 32'(result), 32'h0000);
        chk("b2b_cout2", 32'(carry_out), 32'h1);
      end
    end
    start = 1'b0;
    chk("b2b_d1", 32'(d1), 32'd4);
    chk("b2b_gap", 32'(d2 - d1), 32'd5);

    // reset mid-RUN aborts
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_res", 32'(result), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_ready", 32'(ready), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_cout", 32'(carry_out), 32'h0);
    rst = 1'b0;
    nd  = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("abort_nodone", 32'(nd), 32'd0);
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(n);
    chk("post_lat", 32'(n), 32'd4);
    chk("post_res", 32'(result), 32'h5555);
    chk("post_cout", 32'(carry_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
